// File: rtl/crc_32_frame_appender.sv
// Transmit-path frame controller: forwards payload bytes, optionally zero-pads
// short frames, and appends the CRC-32 FCS least significant byte first.

module crc_32_byte (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        crc_en,
   input  logic        clr,
   input  logic [7:0]  data_in,
   output logic [31:0] crc_out
);
   logic [31:0] crc_q;
   logic [31:0] crc_d;

   // Reflected CRC-32 (poly 0x04C11DB7), one byte per enabled cycle
   always_comb begin
      crc_d = crc_q ^ {24'h0, data_in};
      for (int i = 0; i < 8; i++)
         crc_d = crc_d[0] ? ((crc_d >> 1) ^ 32'hEDB8_8320) : (crc_d >> 1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)      crc_q <= 32'hFFFF_FFFF;
      else if (clr)    crc_q <= 32'hFFFF_FFFF;
      else if (crc_en) crc_q <= crc_d;
   end

   assign crc_out = ~crc_q;
endmodule

module crc_32_frame_appender #(
   parameter int PAD_EN      = 1,
   parameter int MIN_PAYLOAD = 60
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [7:0]  s_data,
   input  logic        s_valid,
   input  logic        s_last,
   output logic        s_ready,
   output logic [7:0]  m_data,
   output logic        m_valid,
   output logic        m_last,
   input  logic        m_ready,
   output logic        busy,
   output logic [15:0] frames_done
);
   typedef enum logic [2:0] {IDLE, PAYLOAD, PAD, WAIT_CRC, FCS} state_t;

   state_t      state, state_d;
   logic [15:0] cnt, cnt_d, cnt_inc;
   logic [31:0] fcs_q, crc_out;
   logic [1:0]  fcs_idx, fcs_idx_d;
   logic        can_load, load, load_last, crc_en, crc_clr, fcs_latch, done_inc;
   logic [7:0]  load_data;

   crc_32_byte u_crc (
      .clk     (clk),
      .rst_n   (rst_n),
      .crc_en  (crc_en),
      .clr     (crc_clr),
      .data_in (load_data),
      .crc_out (crc_out)
   );

   assign can_load = !m_valid || m_ready;
   assign cnt_inc  = (cnt == 16'hFFFF) ? cnt : cnt + 16'd1;
   assign busy     = (state != IDLE);

   always_comb begin
      state_d   = state;
      cnt_d     = cnt;
      fcs_idx_d = fcs_idx;
      s_ready   = 1'b0;
      load      = 1'b0;
      load_data = 8'h00;
      load_last = 1'b0;
      crc_en    = 1'b0;
      crc_clr   = 1'b0;
      fcs_latch = 1'b0;
      done_inc  = 1'b0;
      case (state)
         IDLE, PAYLOAD: begin
            // Gated by rst_n so the port reads 0 while reset is held
            s_ready = can_load && rst_n;
            if (s_valid && s_ready) begin
               load      = 1'b1;
               load_data = s_data;
               crc_en    = 1'b1;
               cnt_d     = cnt_inc;
               state_d   = PAYLOAD;
               if (s_last) begin
                  if (PAD_EN != 0 && {16'd0, cnt_inc} < 32'(MIN_PAYLOAD)) state_d = PAD;
                  else                                                   state_d = WAIT_CRC;
               end
            end
         end
         PAD: begin
            if (can_load) begin
               load   = 1'b1;
               crc_en = 1'b1;
               cnt_d  = cnt_inc;
               if ({16'd0, cnt_inc} == 32'(MIN_PAYLOAD)) state_d = WAIT_CRC;
            end
         end
         WAIT_CRC: begin
            fcs_latch = 1'b1;
            crc_clr   = 1'b1;
            cnt_d     = 16'd0;
            fcs_idx_d = 2'd0;
            state_d   = FCS;
         end
         FCS: begin
            if (can_load) begin
               load      = 1'b1;
               load_data = 8'(fcs_q >> {fcs_idx, 3'b000});
               load_last = (fcs_idx == 2'd3);
               fcs_idx_d = fcs_idx + 2'd1;
               if (fcs_idx == 2'd3) begin
                  done_inc = 1'b1;
                  state_d  = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         cnt         <= 16'd0;
         fcs_q       <= 32'd0;
         fcs_idx     <= 2'd0;
         frames_done <= 16'd0;
      end else begin
         state   <= state_d;
         cnt     <= cnt_d;
         fcs_idx <= fcs_idx_d;
         if (fcs_latch) fcs_q       <= crc_out;
         if (done_inc)  frames_done <= frames_done + 16'd1;
      end
   end

   // Single-entry output register: loads and drains in the same cycle
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_valid <= 1'b0;
         m_data  <= 8'h00;
         m_last  <= 1'b0;
      end else if (load) begin
         m_valid <= 1'b1;
         m_data  <= load_data;
         m_last  <= load_last;
      end else if (m_ready) begin
         m_valid <= 1'b0;
         m_last  <= 1'b0;
      end
   end
endmodule

// File: tb/tb_crc_32_frame_appender.sv
// Randomized bench: expected output stream built from payload + zero pad + CRC-32,
// compared byte by byte on every handshake, with flow-control rules checked each cycle.

module tb_crc_32_frame_appender;
   logic        clk = 1'b0;
   logic        rst_n;
   logic [7:0]  s_data;
   logic        s_valid, s_last, s_ready;
   logic [7:0]  m_data;
   logic        m_valid, m_last, m_ready;
   logic        busy;
   logic [15:0] frames_done;

   int total = 0;
   int bad   = 0;
   int nf    = 0;
   bit rnd   = 0;
   logic [8:0] expq[$];

   crc_32_frame_appender #(.PAD_EN(1), .MIN_PAYLOAD(60)) dut (
      .clk(clk), .rst_n(rst_n),
      .s_data(s_data), .s_valid(s_valid), .s_last(s_last), .s_ready(s_ready),
      .m_data(m_data), .m_valid(m_valid), .m_last(m_last), .m_ready(m_ready),
      .busy(busy), .frames_done(frames_done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string n, input logic [31:0] a, input logic [31:0] x);
      total++;
      if (a !== x) begin
         bad++;
         $display("FAIL %s got=%h exp=%h t=%0t", n, a, x, $time);
      end
   endtask

   function automatic logic [31:0] crc32(input logic [7:0] b[$]);
      logic [31:0] c = 32'hFFFF_FFFF;
      foreach (b[i]) begin
         c ^= {24'h0, b[i]};
         for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
      end
      return ~c;
   endfunction

   initial begin
      m_ready = 1'b1;
      forever begin
         @(posedge clk); #1;
         m_ready = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
      end
   end

   // Per-cycle checker
   initial begin
      logic act, tail, pst, pl;
      logic [7:0] pd;
      logic [8:0] e;
      act = 0; tail = 0; pst = 0; pl = 0; pd = 0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            act = 0; tail = 0; pst = 0;
         end else begin
            if (pst) begin
               chk("hold_valid", 32'(m_valid), 32'd1);
               chk("hold_data",  32'(m_data),  32'(pd));
               chk("hold_last",  32'(m_last),  32'(pl));
            end
            if (m_valid && m_last) begin act = 0; tail = 0; end
            chk("busy", 32'(busy), 32'(act));
            chk("s_ready", 32'(s_ready), tail ? 32'd0 : 32'(!m_valid || m_ready));
            if (m_valid && m_ready) begin
               if (expq.size() == 0) chk("unexpected_byte", 32'(m_data), 32'hFFFF_FFFF);
               else begin
                  e = expq.pop_front();
                  chk("m_data", 32'(m_data), 32'(e[7:0]));
                  chk("m_last", 32'(m_last), 32'(e[8]));
               end
            end
            if (s_valid && s_ready) begin act = 1; if (s_last) tail = 1; end
            pst = m_valid && !m_ready; pd = m_data; pl = m_last;
         end
      end
   end

   task automatic send_byte(input logic [7:0] d, input logic l);
      int t;
      repeat ($urandom_range(0, 2)) begin
         s_valid = 1'b0; s_last = 1'($urandom); s_data = 8'($urandom);
         @(posedge clk); #1;
      end
      s_valid = 1'b1; s_data = d; s_last = l; t = 0;
      forever begin
         @(negedge clk);
         if (s_ready) break;
         t++;
         if (t > 2000) begin chk("accept_timeout", 32'd0, 32'd1); break; end
      end
      @(posedge clk); #1;
      s_valid = 1'b0; s_last = 1'b0;
   endtask

   // Builds the expected stream; abort_at >= 0 sends only that many bytes.
   task automatic send_frame(input logic [7:0] pl[$], input int abort_at, output int nexp);
      logic [7:0] full[$];
      logic [31:0] c;
      int n;
      full = pl;
      while (full.size() < 60) full.push_back(8'h00);
      c = crc32(full);
      n = (abort_at >= 0) ? abort_at : pl.size();
      if (abort_at >= 0) for (int i = 0; i < n; i++) expq.push_back({1'b0, pl[i]});
      else begin
         foreach (full[i]) expq.push_back({1'b0, full[i]});
         for (int i = 0; i < 4; i++) expq.push_back({i == 3, 8'(c >> (8 * i))});
      end
      nexp = expq.size();
      for (int i = 0; i < n; i++) send_byte(pl[i], i == pl.size() - 1);
   endtask

   task automatic finish_frame();
      int t = 0;
      while (expq.size() != 0 || busy || m_valid) begin
         @(negedge clk);
         t++;
         if (t > 5000) begin chk("drain_timeout", 32'(expq.size()), 32'd0); break; end
      end
      @(posedge clk); #1;
      nf++;
      chk("frames_done", 32'(frames_done), 32'(nf));
      chk("busy_idle", 32'(busy), 32'd0);
   endtask

   initial begin
      logic [7:0] dig[$], q[$];
      int ne;
      for (int i = 0; i < 9; i++) dig.push_back(8'h31 + 8'(i));
      rst_n = 1'b0; s_valid = 1'b0; s_last = 1'b0; s_data = 8'h00;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_m_valid", 32'(m_valid), 32'd0);
      chk("rst_m_last",  32'(m_last),  32'd0);
      chk("rst_m_data",  32'(m_data),  32'd0);
      chk("rst_s_ready", 32'(s_ready), 32'd0);
      chk("rst_busy",    32'(busy),    32'd0);
      chk("rst_frames",  32'(frames_done), 32'd0);
      chk("model_crc_check", crc32(dig), 32'hCBF4_3926);
      @(posedge clk); #1; rst_n = 1'b1;
      @(posedge clk); #1;

      // "123456789" padded to 60 bytes
      send_frame(dig, -1, ne);
      chk("pad_frame_len", 32'(ne), 32'd64);
      finish_frame();

      // single zero byte
      q = '{8'h00};
      send_frame(q, -1, ne);
      chk("single_frame_len", 32'(ne), 32'd64);
      finish_frame();

      // random back-pressure
      rnd = 1;
      send_frame(dig, -1, ne);
      finish_frame();
      send_frame(dig, -1, ne);
      finish_frame();

      // exactly minimum length: no pad
      q.delete();
      for (int i = 0; i < 60; i++) q.push_back(8'($urandom));
      send_frame(q, -1, ne);
      chk("exact_min_len", 32'(ne), 32'd64);
      finish_frame();

      // reset mid-frame
      send_frame(dig, 5, ne);
      rst_n = 1'b0;
      @(negedge clk);
      chk("midrst_m_valid", 32'(m_valid), 32'd0);
      chk("midrst_busy",    32'(busy),    32'd0);
      chk("midrst_frames",  32'(frames_done), 32'd0);
      expq.delete();
      nf = 0;
      @(posedge clk); #1; rst_n = 1'b1;
      send_frame(dig, -1, ne);
      finish_frame();

      // random frames, short and long
      for (int f = 0; f < 16; f++) begin
         q.delete();
         for (int i = 0; i < $urandom_range(1, 90); i++) q.push_back(8'($urandom));
         rnd = ($urandom_range(0, 3) != 0);
         send_frame(q, -1, ne);
         finish_frame();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout got=running exp=finished");
      $fatal(1, "timeout");
   end
endmodule
